bsg_mem_1rw_sync_requester: RTL and testbench

Initiator side of the 1RW synchronous SRAM interface. Converts a valid/ready request stream (reads and writes) into single-port sync-RAM commands and returns read data in order on a valid/yumi response stream. It absorbs the RAM's fixed 1-cycle read latency and consumer backpressure with a 2-entry response buffer, so the RAM output never needs to be held. It sits between a cache or DMA engine and any bsg_mem_1rw_sync instance.

---
 rtl/bsg_mem_1rw_sync_requester.sv | 105 ++++++++++
 tb/tb_bsg_mem_1rw_sync_requester.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/bsg_mem_1rw_sync_requester.sv
// bsg_mem_1rw_sync_requester
// Requester (initiator) side of a 1RW synchronous SRAM port. Turns a
// valid/ready request stream into RAM commands and returns read data in
// order on a valid/yumi response stream. A 2-entry response buffer absorbs
// the RAM's 1-cycle read latency plus consumer backpressure, so the RAM
// output never has to be held.
//
// Handshake semantics: a request transfers on a cycle where v_i & ready_and_o
// are both high (ready_and_o is a pure function of registered state and
// reset, never of v_i/w_i/yumi_i); a response transfers on a cycle where
// v_o & yumi_i are both high (yumi_i may only be raised while v_o is high).
module bsg_mem_1rw_sync_requester #(
  parameter int width_p       = 32,
  parameter int els_p         = 16,
  parameter int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,

  input  logic                     v_i,
  input  logic                     w_i,
  input  logic [addr_width_lp-1:0] addr_i,
  input  logic [width_p-1:0]       data_i,
  output logic                     ready_and_o,

  output logic                     v_o,
  output logic [width_p-1:0]       data_o,
  input  logic                     yumi_i,

  output logic                     mem_v_o,
  output logic                     mem_w_o,
  output logic [addr_width_lp-1:0] mem_addr_o,
  output logic [width_p-1:0]       mem_data_o,
  input  logic [width_p-1:0]       mem_data_i
);

  // A read issued last cycle; its data is on mem_data_i this cycle.
  logic               inflight_r;

  // Two-entry response buffer.
  logic [width_p-1:0] fifo_mem [2];
  logic               head_r;
  logic               tail_r;
  logic [1:0]         count_r;

  logic [2:0]         credits_used;
  logic               accept;
  logic               fifo_empty;
  logic               enq;
  logic               deq;

  // Every accepted read holds a credit until it is consumed, either while
  // in flight or while buffered; two credits cover the two buffer slots.
  assign credits_used = {2'b00, inflight_r} + {1'b0, count_r};
  assign ready_and_o  = ~reset_i & (credits_used < 3'd2);
  assign accept       = v_i & ready_and_o;

  // Requests pass straight through to the RAM; only the enable is gated.
  assign mem_v_o      = accept;
  assign mem_w_o      = w_i;
  assign mem_addr_o   = addr_i;
  assign mem_data_o   = data_i;

  assign fifo_empty   = (count_r == 2'd0);

  // Response side: bypass returning RAM data when the buffer is empty so a
  // read can be consumed one cycle after it was accepted.
  assign v_o          = ~reset_i & (inflight_r | ~fifo_empty);
  assign data_o       = fifo_empty ? mem_data_i : fifo_mem[head_r];

  // Returning data is buffered unless it was consumed through the bypass.
  assign enq          = ~reset_i & inflight_r & (~fifo_empty | ~yumi_i);
  assign deq          = ~reset_i & yumi_i & ~fifo_empty;

  // Control state: in-flight flag, buffer pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      inflight_r <= 1'b0;
      head_r     <= 1'b0;
      tail_r     <= 1'b0;
      count_r    <= 2'd0;
    end else begin
      inflight_r <= accept & ~w_i;
      if (enq) tail_r <= ~tail_r;
      if (deq) head_r <= ~head_r;
      case ({enq, deq})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Buffer storage; contents are only meaningful under count_r.
  always_ff @(posedge clk_i) begin
    if (enq) fifo_mem[tail_r] <= mem_data_i;
  end

  overflow_a: assert property (@(posedge clk_i) disable iff (reset_i)
    !(enq && (count_r == 2'd2)));

  yumi_without_valid_a: assert property (@(posedge clk_i) disable iff (reset_i)
    !(yumi_i && !v_o));

endmodule

// File: tb/tb_bsg_mem_1rw_sync_requester.sv
// Bench for bsg_mem_1rw_sync_requester: a behavioural 1RW sync RAM sits on
// the memory port; expected responses come from a shadow memory and a queue
// of outstanding read results.
module tb_bsg_mem_1rw_sync_requester;

  localparam int W  = 16;
  localparam int N  = 16;
  localparam int AW = 4;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          v_in, w_in, yumi;
  logic [AW-1:0] addr_in;
  logic [W-1:0]  data_in;
  logic          ready, v_out;
  logic [W-1:0]  data_out;
  logic          mem_v, mem_w;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  bsg_mem_1rw_sync_requester #(.width_p(W), .els_p(N)) dut (
    .clk_i(clk), .reset_i(rst),
    .v_i(v_in), .w_i(w_in), .addr_i(addr_in), .data_i(data_in),
    .ready_and_o(ready),
    .v_o(v_out), .data_o(data_out), .yumi_i(yumi),
    .mem_v_o(mem_v), .mem_w_o(mem_w), .mem_addr_o(mem_addr),
    .mem_data_o(mem_wdata), .mem_data_i(mem_rdata)
  );

  // Environment RAM: 1RW synchronous, read data valid the cycle after.
  logic [W-1:0] ram [N];
  always @(posedge clk) begin
    if (mem_v) begin
      if (mem_w) ram[mem_addr] <= mem_wdata;
      else       mem_rdata     <= ram[mem_addr];
    end
  end

  // ---------------- scoreboard / reference model ----------------
  logic [W-1:0] exp_q[$];   // results of accepted, not yet consumed reads
  logic [W-1:0] shadow [N]; // architectural memory contents
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare against the model, advance model.
  // Entered and left 1 time unit after a rising edge.
  task automatic step(input logic s_rst, input logic s_v, input logic s_w,
                      input logic [AW-1:0] s_a, input logic [W-1:0] s_d, input logic s_y,
                      output logic o_ready, output logic o_mem_v,
                      output logic o_v, output logic [W-1:0] o_data);
    logic e_ready, e_v, e_acc;
    rst = s_rst; v_in = s_v; w_in = s_w; addr_in = s_a; data_in = s_d; yumi = s_y;
    #4;
    e_ready = !s_rst && (exp_q.size() < 2);
    e_v     = !s_rst && (exp_q.size() > 0);
    e_acc   = s_v && e_ready;
    check("ready_and_o", 32'(ready), 32'(e_ready));
    check("mem_v_o", 32'(mem_v), 32'(e_acc));
    check("v_o", 32'(v_out), 32'(e_v));
    if (e_v) check("data_o", 32'(data_out), 32'(exp_q[0]));
    if (e_acc) begin
      check("mem_w_o", 32'(mem_w), 32'(s_w));
      check("mem_addr_o", 32'(mem_addr), 32'(s_a));
      if (s_w) check("mem_data_o", 32'(mem_wdata), 32'(s_d));
    end
    o_ready = ready; o_mem_v = mem_v; o_v = v_out; o_data = data_out;
    if (s_rst) begin
      exp_q.delete();
    end else begin
      if (s_y && e_v) void'(exp_q.pop_front());
      if (e_acc) begin
        if (s_w) shadow[s_a] = s_d;
        else     exp_q.push_back(shadow[s_a]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          v;
    logic          w;
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
    logic          yumi;
    logic          e_ready;
    logic          e_mem_v;
    logic          e_v;
    logic [W-1:0]  e_data;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic w, input logic [AW-1:0] a,
                              input logic [W-1:0] d, input logic y, input logic er,
                              input logic em, input logic ev, input logic [W-1:0] ed);
    vec_t t;
    t.v = v; t.w = w; t.addr = a; t.data = d; t.yumi = y;
    t.e_ready = er; t.e_mem_v = em; t.e_v = ev; t.e_data = ed;
    return t;
  endfunction

  vec_t tbl [22];

  initial begin
    logic          r_ready, r_mem_v, r_v;
    logic [W-1:0]  r_data;
    int            v_run;
    int            max_out;

    // Table assumes memory[i] = 3*i before it starts (addr 5 gets rewritten).
    //              v     w     addr   data       yumi  rdy   memv  v_o   data_o
    // write 5 then read 5
    tbl[0]  = mk(1'b1, 1'b1, 4'd5, 16'hA5A5, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    tbl[1]  = mk(1'b1, 1'b0, 4'd5, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    tbl[2]  = mk(1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 16'hA5A5);
    // reads 1,2,3 with consumer stalled
    tbl[3]  = mk(1'b1, 1'b0, 4'd1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    tbl[4]  = mk(1'b1, 1'b0, 4'd2, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'd3);
    tbl[5]  = mk(1'b1, 1'b0, 4'd3, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'd3);
    tbl[6]  = mk(1'b1, 1'b0, 4'd3, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'd3);
    tbl[7]  = mk(1'b1, 1'b0, 4'd3, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'd3);
    tbl[8]  = mk(1'b1, 1'b0, 4'd3, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'd6);
    tbl[9]  = mk(1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'd6);
    tbl[10] = mk(1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 16'd9);
    tbl[11] = mk(1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    // full buffer blocks a write until a yumi frees a slot
    tbl[12] = mk(1'b1, 1'b0, 4'd7, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    tbl[13] = mk(1'b1, 1'b0, 4'd8, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'd21);
    tbl[14] = mk(1'b1, 1'b1, 4'd9, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 16'd21);
    tbl[15] = mk(1'b1, 1'b1, 4'd9, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b1, 16'd21);
    tbl[16] = mk(1'b1, 1'b1, 4'd9, 16'h1234, 1'b0, 1'b1, 1'b1, 1'b1, 16'd24);
    tbl[17] = mk(1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 16'd24);
    tbl[18] = mk(1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    // the write produced no response; its data is readable
    tbl[19] = mk(1'b1, 1'b0, 4'd9, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    tbl[20] = mk(1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 16'h1234);
    tbl[21] = mk(1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);

    // Reset state.
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 1'b0, 4'd0, 16'h0, 1'b0, r_ready, r_mem_v, r_v, r_data);

    // Preload memory[i] = 3*i through the requester.
    for (int i = 0; i < N; i++)
      step(1'b0, 1'b1, 1'b1, AW'(i), W'(3 * i), 1'b0, r_ready, r_mem_v, r_v, r_data);

    // Back-to-back reads 0..7 with the consumer always taking.
    v_run = 0;
    for (int i = 0; i < 9; i++) begin
      step(1'b0, (i < 8), 1'b0, AW'(i), 16'h0, (exp_q.size() > 0),
           r_ready, r_mem_v, r_v, r_data);
      if (i < 8) check($sformatf("b2b_ready%0d", i), 32'(r_ready), 32'd1);
      if (i > 0) begin
        check($sformatf("b2b_data%0d", i - 1), 32'(r_data), 32'(3 * (i - 1)));
        if (r_v) v_run++;
      end
    end
    check("b2b_valid_cycles", 32'(v_run), 32'd8);

    // Directed table.
    for (int i = 0; i < 22; i++) begin
      step(1'b0, tbl[i].v, tbl[i].w, tbl[i].addr, tbl[i].data, tbl[i].yumi,
           r_ready, r_mem_v, r_v, r_data);
      check($sformatf("tbl%0d_ready", i), 32'(r_ready), 32'(tbl[i].e_ready));
      check($sformatf("tbl%0d_mem_v", i), 32'(r_mem_v), 32'(tbl[i].e_mem_v));
      check($sformatf("tbl%0d_v_o", i), 32'(r_v), 32'(tbl[i].e_v));
      if (tbl[i].e_v) check($sformatf("tbl%0d_data_o", i), 32'(r_data), 32'(tbl[i].e_data));
    end

    // Reset right after a read is accepted: the outstanding read vanishes.
    step(1'b0, 1'b1, 1'b0, 4'd2, 16'h0, 1'b0, r_ready, r_mem_v, r_v, r_data);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b0, 4'd3, 16'h0, 1'b0, r_ready, r_mem_v, r_v, r_data);
      check("rst_ready", 32'(r_ready), 32'd0);
      check("rst_mem_v", 32'(r_mem_v), 32'd0);
      check("rst_v_o", 32'(r_v), 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0, r_ready, r_mem_v, r_v, r_data);
      check("post_rst_v_o", 32'(r_v), 32'd0);
      check("post_rst_ready", 32'(r_ready), 32'd1);
    end

    // Randomised traffic against the model, with occasional resets.
    max_out = 0;
    for (int i = 0; i < 400; i++) begin
      logic rr, rv, rw, ry;
      rr = ($urandom_range(0, 59) == 0);
      rv = ($urandom_range(0, 3) != 0);
      rw = ($urandom_range(0, 2) == 0);
      ry = !rr && (exp_q.size() > 0) && ($urandom_range(0, 2) != 0);
      step(rr, rv, rw, AW'($urandom_range(0, N - 1)), W'($urandom),
           ry, r_ready, r_mem_v, r_v, r_data);
      if (exp_q.size() > max_out) max_out = exp_q.size();
    end
    check("rand_max_outstanding_le2", 32'(max_out <= 2), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
